// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux_arb channel selector: arbitration mode
// encodings and the output-register state type.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin / fixed-priority picker: finds the first requester
// at or above the start index by priority-encoding a doubled, masked request vector.
module mux_arb_rr_pick
    import mux_arb_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            rr_en,
    output logic [NCH-1:0]  gnt_onehot,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [SELW-1:0]  w_start;
    logic [2*NCH-1:0] w_dbl;
    logic [2*NCH-1:0] w_masked;
    logic             w_hit;

    // Fixed priority is simply a search that always starts at channel 0.
    assign w_start = (rr_en == MODE_FIXED) ? '0 : ptr;
    assign w_dbl   = {req, req};
    assign any     = |req;

    always_comb begin
        w_masked = '0;
        for (int j = 0; j < int'(2 * NCH); j++) begin
            w_masked[j] = w_dbl[j] && (j >= int'(w_start));
        end
    end

    // The upper copy supplies the wrapped-around candidates below the start index.
    always_comb begin
        w_hit      = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        for (int j = 0; j < int'(2 * NCH); j++) begin
            if (!w_hit && w_masked[j]) begin
                w_hit   = 1'b1;
                gnt_idx = (j >= int'(NCH)) ? SELW'(j - int'(NCH)) : SELW'(j);
            end
        end
        if (w_hit) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_arb.sv
// N-channel valid/ready selector with a registered output beat and a run-time
// choice of fixed-priority or round-robin arbitration.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 rr_en,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    out_state_e      r_state;
    out_state_e      w_state_nxt;
    logic            r_run;
    logic [SELW-1:0] r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0] r_sel;

    logic            w_load;
    logic            w_xfer;
    logic [NCH-1:0]  w_gnt_onehot;
    logic [SELW-1:0] w_gnt_idx;
    logic            w_any;
    logic [WIDTH-1:0] w_sel_data;
    logic [SELW-1:0] w_ptr_nxt;

    mux_arb_rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_pick (
        .req        (in_valid),
        .ptr        (r_ptr),
        .rr_en      (rr_en),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    // Output register occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = w_xfer ? ST_FULL : ST_EMPTY;
        end
    end

    // r_run keeps in_ready low until the first edge after reset is released.
    always_comb begin
        w_load   = (r_state == ST_EMPTY) || out_ready;
        w_xfer   = r_run && w_load && w_any;
        in_ready = w_xfer ? w_gnt_onehot : '0;
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (w_gnt_onehot[i]) begin
                w_sel_data = w_sel_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == SELW'(NCH - 1)) ? '0 : w_gnt_idx + SELW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run  <= 1'b0;
            r_ptr  <= '0;
            r_data <= '0;
            r_sel  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_xfer) begin
                r_data <= w_sel_data;
                r_sel  <= w_gnt_idx;
                r_ptr  <= w_ptr_nxt;
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule
